// File: rtl/acs_unit.sv
// rtl/acs_unit.sv - K=3 (7,5) Viterbi add-compare-select unit with a per-frame IDLE/RUN/DONE FSM.
// Defining ACS_BEST_ST_EN adds a registered argmin of the normalised path metrics on o_best_st.
module acs_unit #(
   parameter int PM_W      = 6,
   parameter int PM_INIT   = 16,
   parameter int FRAME_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic       i_valid,
   input  logic [1:0] i_rx,
   output logic [1:0] o_prv_st_00,
   output logic [1:0] o_prv_st_01,
   output logic [1:0] o_prv_st_10,
   output logic [1:0] o_prv_st_11,
   output logic       o_en_memory,
   output logic [1:0] o_best_st,
   output logic       o_frame_done,
   output logic       o_busy
);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [PM_W-1:0] PM_MAX   = {PM_W{1'b1}};
   localparam logic [PM_W-1:0] PM_START = PM_W'(PM_INIT);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [PM_W-1:0] pm      [4];
   logic [PM_W-1:0] pm_new  [4];
   logic [PM_W-1:0] pm_norm [4];
   logic [PM_W-1:0] pm_min;
   logic [1:0]      prv     [4];
   logic [1:0]      prv_new [4];
   logic            accept, last_sym;

   assign accept   = (state == RUN) && i_valid;
   assign last_sym = accept && (cnt == CNT_W'(FRAME_LEN - 1));

   function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] cw);
      logic [1:0] d;
      d = rx ^ cw;
      return {1'b0, d[1]} + {1'b0, d[0]};
   endfunction

   function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] m, input logic [1:0] b);
      logic [PM_W:0] s;
      s = {1'b0, m} + {{(PM_W-1){1'b0}}, b};
      return s[PM_W] ? PM_MAX : s[PM_W-1:0];
   endfunction

   // State {u,b1} is reached from {b1,0} (candidate a) or {b1,1} (candidate b).
   always_comb begin : acs
      logic [1:0]      st;
      logic [1:0]      cw_a, cw_b;
      logic [PM_W-1:0] cand_a, cand_b;
      pm_min = PM_MAX;
      for (int s = 0; s < 4; s++) begin
         st         = 2'(s);
         cw_a       = {st[1] ^ st[0], st[1]};
         cw_b       = ~cw_a;
         cand_a     = sat_add(pm[{st[0], 1'b0}], branch_metric(i_rx, cw_a));
         cand_b     = sat_add(pm[{st[0], 1'b1}], branch_metric(i_rx, cw_b));
         pm_new[s]  = cand_a;
         prv_new[s] = {st[0], 1'b0};
         if (cand_b < cand_a) begin
            pm_new[s]  = cand_b;
            prv_new[s] = {st[0], 1'b1};
         end
         if (pm_new[s] < pm_min) pm_min = pm_new[s];
      end
      for (int s = 0; s < 4; s++) pm_norm[s] = pm_new[s] - pm_min;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start)  state_nxt = RUN;
         RUN:     if (last_sym) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         o_en_memory <= 1'b0;
         pm[0]       <= '0;
         for (int s = 0; s < 4; s++) prv[s] <= 2'b00;
         for (int s = 1; s < 4; s++) pm[s]  <= PM_START;
      end else begin
         o_en_memory <= accept;
         if (state == IDLE && i_start) begin
            cnt   <= '0;
            pm[0] <= '0;
            for (int s = 1; s < 4; s++) pm[s] <= PM_START;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
            for (int s = 0; s < 4; s++) begin
               pm[s]  <= pm_norm[s];
               prv[s] <= prv_new[s];
            end
         end
      end
   end

`ifdef ACS_BEST_ST_EN
   logic [1:0] best_new, best_q;

   // Strict compare keeps the lowest-numbered state on ties.
   always_comb begin
      best_new = 2'b00;
      for (int s = 1; s < 4; s++)
         if (pm_norm[s] < pm_norm[best_new]) best_new = 2'(s);
   end

   always_ff @(posedge clk) begin
      if (rst)         best_q <= 2'b00;
      else if (accept) best_q <= best_new;
   end

   assign o_best_st = best_q;
`else
   assign o_best_st = 2'b00;
`endif

   assign o_prv_st_00  = prv[0];
   assign o_prv_st_01  = prv[1];
   assign o_prv_st_10  = prv[2];
   assign o_prv_st_11  = prv[3];
   assign o_busy       = (state == RUN);
   assign o_frame_done = (state == DONE);
endmodule

// File: doc/acs_unit.md
ACS_UNIT -- requirements
Module: acs_unit

Interface
REQ-001 SHALL have parameter PM_W, default 6: path-metric register width in bits.
REQ-002 SHALL have parameter PM_INIT, default 16: reset and start metric for states 01, 10 and 11.
REQ-003 SHALL have parameter FRAME_LEN, default 8: symbols per frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_start, input, 1 bit: begin a new frame.
REQ-007 SHALL have port i_valid, input, 1 bit: i_rx carries a symbol this cycle.
REQ-008 SHALL have port i_rx, input, 2 bits: hard-decision received code word {g0,g1}.
REQ-009 SHALL have ports o_prv_st_00, o_prv_st_01, o_prv_st_10 and o_prv_st_11, output, 2 bits each: survivor predecessor of each state.
REQ-010 SHALL have port o_en_memory, output, 1 bit: decisions are valid; drives the survivor-memory enable.
REQ-011 SHALL have port o_best_st, output, 2 bits: state with the minimum metric.
REQ-012 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-013 SHALL have port o_busy, output, 1 bit: high while in RUN.

Function
REQ-014 SHALL use the K=3, (7,5) trellis: state {b1,b2}; input u moves it to {u,b1}; code word {u^b1^b2, u^b2}.
REQ-015 SHALL use these predecessors and code words:
- 00: from 00 (cw 00), from 01 (cw 11)
- 01: from 10 (cw 10), from 11 (cw 01)
- 10: from 00 (cw 11), from 01 (cw 00)
- 11: from 10 (cw 01), from 11 (cw 10)
REQ-016 SHALL compute the branch metric as the Hamming distance between i_rx and the code word (0..2).
REQ-017 SHALL form each candidate as predecessor metric plus branch metric, saturating at 2^PM_W-1.
REQ-018 SHALL select the smaller candidate; on a tie, the lower-numbered predecessor wins.
REQ-019 SHALL normalise every step: subtract the minimum of the four new metrics from all four, so the minimum stored metric is always 0.
REQ-020 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-021 In IDLE, i_start SHALL load metrics {0, PM_INIT, PM_INIT, PM_INIT}, clear the symbol counter and enter RUN; i_valid in the same cycle SHALL be ignored.
REQ-022 In RUN, each i_valid cycle SHALL perform one ACS step and increment the counter; cycles without i_valid SHALL hold all state.
REQ-023 Latency SHALL be 1 cycle: decisions, o_best_st and o_en_memory=1 are registered on the edge that accepts the symbol.
REQ-024 o_en_memory SHALL otherwise be 0; decision outputs SHALL hold their last values.
REQ-025 On the FRAME_LEN-th accepted symbol, the FSM SHALL enter DONE; DONE SHALL assert o_frame_done for exactly one cycle, then return to IDLE.
REQ-026 i_start in RUN or DONE SHALL be ignored; i_valid in IDLE or DONE SHALL be ignored.
REQ-027 Metrics SHALL persist after DONE until the next i_start.

Reset
REQ-028 rst SHALL take priority over every other input.
REQ-029 On reset: state IDLE, counter 0, metrics {0, PM_INIT, PM_INIT, PM_INIT}, all o_prv_st_* = 00, o_best_st = 00, o_en_memory = 0, o_frame_done = 0, o_busy = 0.
REQ-030 Reset during RUN SHALL abandon the frame, with no o_frame_done pulse.

Configuration
REQ-031 With macro ACS_BEST_ST_EN defined, o_best_st SHALL be the state with the minimum normalised metric; ties go to the lowest state number.
REQ-032 Without ACS_BEST_ST_EN, o_best_st SHALL be tied to 00, the port SHALL remain, and the argmin logic SHALL be absent.

Verification
REQ-033 Reset, i_start, then i_rx=00 -> next cycle: o_prv_st_00=00, o_prv_st_01=10, o_prv_st_10=00, o_prv_st_11=10; o_best_st=00; o_en_memory=1.
REQ-034 Reset, i_start, then i_rx=11 -> next cycle: o_prv_st_10=00, o_prv_st_00=00; o_best_st=10 (macro on) or 00 (macro off).
REQ-035 Encode 1,0,1,1,0,0,0,0 as (7,5) words, feed 8 symbols with random i_valid gaps -> 8 o_en_memory pulses, then one o_frame_done pulse, then o_busy=0.
REQ-036 Assert rst after 3 symbols -> next cycle all outputs at reset values, no o_frame_done; a new i_start restarts the count from 0.
REQ-037 Feed 40 symbols of all-11 words over 5 frames -> no metric exceeds 2^PM_W-1, and the minimum metric is 0 after every step.
